// File: rtl/steering_y_sched.sv
// Y-axis steering command scheduler: conditions joystick samples and commits
// them to the PWM datapath once per frame with slew limiting and a stall failsafe.
module steering_y_sched #(
    parameter int CENTER         = 512,
    parameter int DEADZONE       = 16,
    parameter int LIMIT_LO       = 64,
    parameter int LIMIT_HI       = 960,
    parameter int MAX_STEP       = 8,
    parameter int TIMEOUT_FRAMES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic       frame_start,
    output logic [9:0] y_val,
    output logic       y_update,
    output logic       failsafe
);

    localparam logic [9:0]        CENTER_V   = 10'(CENTER);
    localparam logic [9:0]        LIMIT_LO_V = 10'(LIMIT_LO);
    localparam logic [9:0]        LIMIT_HI_V = 10'(LIMIT_HI);
    localparam logic signed [10:0] CENTER_S  = 11'(CENTER);
    localparam logic signed [10:0] DZ_S      = 11'(DEADZONE);
    localparam logic signed [10:0] STEP_S    = 11'(MAX_STEP);
    localparam logic [9:0]        STEP_V     = 10'(MAX_STEP);
    localparam logic [7:0]        TIMEOUT_V  = 8'(TIMEOUT_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        FAILSAFE
    } state_t;

    state_t     state;
    logic [9:0] act_tgt;
    logic [9:0] pend_val;
    logic       pending;
    logic [7:0] frame_cnt;

    logic              accept;
    logic signed [10:0] dev;
    logic signed [10:0] dev_mag;
    logic [9:0]        cond_val;
    logic [9:0]        eff;
    logic [7:0]        frame_cnt_inc;
    logic              timeout_hit;
    logic [9:0]        y_next;

    // IDLE swallows samples; otherwise one sample may wait for the next frame.
    assign sample_ready = (state == IDLE) || !pending;
    assign failsafe     = (state == FAILSAFE);
    assign accept       = sample_valid && sample_ready;

    // Move cur toward tgt by at most MAX_STEP, landing exactly on tgt when close.
    function automatic logic [9:0] slew(input logic [9:0] cur, input logic [9:0] tgt);
        logic signed [10:0] diff;
        diff = signed'({1'b0, tgt}) - signed'({1'b0, cur});
        if (diff > STEP_S)
            return cur + STEP_V;
        else if (diff < -STEP_S)
            return cur - STEP_V;
        else
            return tgt;
    endfunction

    always_comb begin
        dev      = signed'({1'b0, sample_in}) - CENTER_S;
        dev_mag  = (dev < 0) ? -dev : dev;
        cond_val = (dev_mag <= DZ_S) ? CENTER_V : sample_in;
        if (cond_val < LIMIT_LO_V)
            cond_val = LIMIT_LO_V;
        if (cond_val > LIMIT_HI_V)
            cond_val = LIMIT_HI_V;
    end

    // A same-cycle accept clears the counter, so it also suppresses the timeout.
    always_comb begin
        eff           = pending ? pend_val : act_tgt;
        frame_cnt_inc = (frame_cnt < TIMEOUT_V) ? frame_cnt + 8'd1 : frame_cnt;
        timeout_hit   = (state == TRACK) && frame_start && !accept
                        && (frame_cnt_inc == TIMEOUT_V);
        y_next        = y_val;
        if (frame_start) begin
            case (state)
                IDLE:     y_next = CENTER_V;
                TRACK:    y_next = slew(y_val, timeout_hit ? CENTER_V : eff);
                FAILSAFE: y_next = slew(y_val, CENTER_V);
                default:  y_next = CENTER_V;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            y_val     <= CENTER_V;
            act_tgt   <= CENTER_V;
            pend_val  <= CENTER_V;
            pending   <= 1'b0;
            frame_cnt <= 8'd0;
            y_update  <= 1'b0;
        end else begin
            y_val    <= y_next;
            y_update <= (y_next != y_val);
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        act_tgt <= CENTER_V;
                        pending <= 1'b0;
                    end
                    if (enable) begin
                        state     <= TRACK;
                        frame_cnt <= 8'd0;
                        pending   <= 1'b0;
                    end
                end
                TRACK: begin
                    if (frame_start) begin
                        act_tgt   <= timeout_hit ? CENTER_V : eff;
                        pending   <= 1'b0;
                        frame_cnt <= frame_cnt_inc;
                        if (timeout_hit)
                            state <= FAILSAFE;
                    end
                    // Accept only happens with pending clear, so it overrides the commit.
                    if (accept) begin
                        pend_val  <= cond_val;
                        pending   <= 1'b1;
                        frame_cnt <= 8'd0;
                    end
                end
                FAILSAFE: begin
                    if (frame_start) begin
                        act_tgt <= CENTER_V;
                        pending <= 1'b0;
                    end
                    if (accept) begin
                        pend_val  <= cond_val;
                        pending   <= 1'b1;
                        frame_cnt <= 8'd0;
                        state     <= TRACK;
                    end
                end
                default: state <= IDLE;
            endcase
            if (!enable)
                state <= IDLE;
        end
    end

endmodule

// File: tb/tb_steering_y_sched.sv
// Directed bench for steering_y_sched: hand-computed y_val trajectories across
// deadzone, clamping, frame-aligned commit, timeout failsafe, enable drop and reset.
module tb_steering_y_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [9:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       frame_start;
    logic [9:0] y_val;
    logic       y_update;
    logic       failsafe;

    int vectors     = 0;
    int miscompares = 0;

    steering_y_sched dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_start  (frame_start),
        .y_val        (y_val),
        .y_update     (y_update),
        .failsafe     (failsafe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Waits a bounded time for ready, then presents the sample for one cycle.
    task automatic send(input logic [9:0] v);
        int waited = 0;
        while (!sample_ready && waited < 20) begin
            tick();
            waited++;
        end
        vectors++;
        if (sample_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL send_ready got %b want 1 (sample %0d)", sample_ready, v);
        end
        sample_valid = 1'b1;
        sample_in    = v;
        tick();
        sample_valid = 1'b0;
    endtask

    // Re-sends the target before every frame so the timeout never runs.
    task automatic ramp(input logic [9:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            send(v);
            frame();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_in = 10'd0; frame_start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (y_val !== 10'd512) begin miscompares++; $display("[TB] FAIL reset_y_val got %0d want 512", y_val); end
        vectors++;
        if (sample_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready got %b want 1", sample_ready); end
        vectors++;
        if (failsafe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_failsafe got %b want 0", failsafe); end
        vectors++;
        if (y_update !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_y_update got %b want 0", y_update); end
    endtask

    task automatic test_timeout();
        logic any_update = 1'b0;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 49; i++) begin
            frame();
            any_update |= y_update;
        end
        vectors++;
        if (failsafe !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_49 failsafe got %b want 0", failsafe); end
        frame();
        any_update |= y_update;
        vectors++;
        if (failsafe !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_50 failsafe got %b want 1", failsafe); end
        vectors++;
        if (y_val !== 10'd512) begin miscompares++; $display("[TB] FAIL timeout_y_val got %0d want 512", y_val); end
        vectors++;
        if (any_update !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_no_update got %b want 0", any_update); end
    endtask

    task automatic test_deadzone_ramp();
        int updates = 0;
        send(10'd520);
        vectors++;
        if (failsafe !== 1'b0) begin miscompares++; $display("[TB] FAIL dz_exit_failsafe got %b want 0", failsafe); end
        vectors++;
        if (sample_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL dz_ready_pending got %b want 0", sample_ready); end
        frame();
        vectors++;
        if (y_val !== 10'd512 || y_update !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dz_commit got y_val=%0d upd=%b want 512/0", y_val, y_update);
        end
        send(10'd600);
        for (int k = 1; k <= 11; k++) begin
            frame();
            if (y_update === 1'b1) updates++;
            vectors++;
            if (y_val !== 10'(512 + 8 * k)) begin
                miscompares++;
                $display("[TB] FAIL ramp600_step%0d got %0d want %0d", k, y_val, 512 + 8 * k);
            end
        end
        vectors++;
        if (updates != 11) begin miscompares++; $display("[TB] FAIL ramp600_updates got %0d want 11", updates); end
        frame();
        vectors++;
        if (y_val !== 10'd600 || y_update !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ramp600_hold got y_val=%0d upd=%b want 600/0", y_val, y_update);
        end
    endtask

    task automatic test_clamp();
        ramp(10'd1000, 44);
        vectors++;
        if (y_val !== 10'd952) begin miscompares++; $display("[TB] FAIL clamp_hi_pre got %0d want 952", y_val); end
        ramp(10'd1000, 1);
        vectors++;
        if (y_val !== 10'd960 || y_update !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL clamp_hi_land got y_val=%0d upd=%b want 960/1", y_val, y_update);
        end
        ramp(10'd1000, 1);
        vectors++;
        if (y_val !== 10'd960 || y_update !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clamp_hi_stop got y_val=%0d upd=%b want 960/0", y_val, y_update);
        end
        ramp(10'd10, 111);
        vectors++;
        if (y_val !== 10'd72) begin miscompares++; $display("[TB] FAIL clamp_lo_pre got %0d want 72", y_val); end
        ramp(10'd10, 1);
        vectors++;
        if (y_val !== 10'd64) begin miscompares++; $display("[TB] FAIL clamp_lo_land got %0d want 64", y_val); end
        ramp(10'd10, 1);
        vectors++;
        if (y_val !== 10'd64 || y_update !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clamp_lo_stop got y_val=%0d upd=%b want 64/0", y_val, y_update);
        end
    endtask

    task automatic test_same_cycle();
        ramp(10'd512, 56);
        vectors++;
        if (y_val !== 10'd512) begin miscompares++; $display("[TB] FAIL same_setup got %0d want 512", y_val); end
        sample_valid = 1'b1;
        sample_in    = 10'd700;
        frame_start  = 1'b1;
        tick();
        sample_valid = 1'b0;
        frame_start  = 1'b0;
        vectors++;
        if (y_val !== 10'd512 || y_update !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL same_old_tgt got y_val=%0d upd=%b want 512/0", y_val, y_update);
        end
        tick();
        vectors++;
        if (sample_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL same_ready_held got %b want 0", sample_ready); end
        frame();
        vectors++;
        if (y_val !== 10'd520 || y_update !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL same_new_tgt got y_val=%0d upd=%b want 520/1", y_val, y_update);
        end
        vectors++;
        if (sample_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL same_ready_back got %b want 1", sample_ready); end
    endtask

    task automatic test_failsafe_recover();
        ramp(10'd600, 10);
        vectors++;
        if (y_val !== 10'd600) begin miscompares++; $display("[TB] FAIL fs_setup got %0d want 600", y_val); end
        send(10'd900);
        for (int i = 0; i < 49; i++) frame();
        vectors++;
        if (failsafe !== 1'b0 || y_val !== 10'd900) begin
            miscompares++;
            $display("[TB] FAIL fs_pre got fs=%b y_val=%0d want 0/900", failsafe, y_val);
        end
        frame();
        vectors++;
        if (failsafe !== 1'b1 || y_val !== 10'd892) begin
            miscompares++;
            $display("[TB] FAIL fs_enter got fs=%b y_val=%0d want 1/892", failsafe, y_val);
        end
        for (int i = 0; i < 12; i++) frame();
        vectors++;
        if (y_val !== 10'd796) begin miscompares++; $display("[TB] FAIL fs_slew got %0d want 796", y_val); end
        send(10'd800);
        vectors++;
        if (failsafe !== 1'b0) begin miscompares++; $display("[TB] FAIL fs_exit got %b want 0", failsafe); end
        frame();
        vectors++;
        if (y_val !== 10'd800 || y_update !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL fs_track got y_val=%0d upd=%b want 800/1", y_val, y_update);
        end
    endtask

    task automatic test_enable_drop();
        ramp(10'd400, 30);
        vectors++;
        if (y_val !== 10'd560) begin miscompares++; $display("[TB] FAIL drop_setup got %0d want 560", y_val); end
        enable = 1'b0;
        tick();
        tick();
        tick();
        vectors++;
        if (y_val !== 10'd560 || y_update !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drop_hold got y_val=%0d upd=%b want 560/0", y_val, y_update);
        end
        frame();
        vectors++;
        if (y_val !== 10'd512 || y_update !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL drop_snap got y_val=%0d upd=%b want 512/1", y_val, y_update);
        end
        send(10'd900);
        frame();
        vectors++;
        if (y_val !== 10'd512 || sample_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL idle_discard got y_val=%0d rdy=%b want 512/1", y_val, sample_ready);
        end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        tick();
        send(10'd900);
        frame();
        vectors++;
        if (y_val !== 10'd520) begin miscompares++; $display("[TB] FAIL mid_setup got %0d want 520", y_val); end
        rst          = 1'b1;
        frame_start  = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 10'd900;
        tick();
        rst          = 1'b0;
        frame_start  = 1'b0;
        sample_valid = 1'b0;
        vectors++;
        if (y_val !== 10'd512 || y_update !== 1'b0 || failsafe !== 1'b0 || sample_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_reset got y_val=%0d upd=%b fs=%b rdy=%b want 512/0/0/1",
                     y_val, y_update, failsafe, sample_ready);
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_deadzone_ramp();
        test_clamp();
        test_same_cycle();
        test_failsafe_recover();
        test_enable_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
